// File: rtl/soft_start_sequencer_if.sv
// rtl/soft_start_sequencer_if.sv - switch/fault inputs and PWM command outputs of the soft-start sequencer
interface soft_start_sequencer_if #(
  parameter int DUTY_W = 8
);
  logic              i_enable;
  logic              i_fault;
  logic [DUTY_W-1:0] i_target_duty;
  logic [DUTY_W-1:0] o_duty;
  logic              o_pwm_en;
  logic              o_done;
  logic              o_fault_latched;
  logic [2:0]        o_state;

  modport master (
    output i_enable, i_fault, i_target_duty,
    input  o_duty, o_pwm_en, o_done, o_fault_latched, o_state
  );

  modport slave (
    input  i_enable, i_fault, i_target_duty,
    output o_duty, o_pwm_en, o_done, o_fault_latched, o_state
  );
endinterface

// File: rtl/soft_start_sequencer.sv
// rtl/soft_start_sequencer.sv - slew-limited duty ramp with latched fault shutdown for the PWM generator
module soft_start_sequencer #(
  parameter int DUTY_W    = 8,
  parameter int RAMP_TICK = 2000,
  parameter int COOLDOWN  = 200000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  soft_start_sequencer_if.slave bus
);
  localparam int TICK_W = $clog2(RAMP_TICK);
  localparam int CD_W   = $clog2(COOLDOWN + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RAMP_UP   = 3'd1,
    RUN       = 3'd2,
    RAMP_DOWN = 3'd3,
    FAULT     = 3'd4
  } state_t;

  logic              en_q1, en_s, flt_q1, flt_s;
  state_t            state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [CD_W-1:0]   cool_q, cool_d;
  logic              pwm_en_q, done_q, fault_q;
  logic              step;
  logic [DUTY_W-1:0] target;

  assign target = bus.i_target_duty;
  assign step   = (tick_q == TICK_W'(RAMP_TICK - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q1  <= 1'b0;
      en_s   <= 1'b0;
      flt_q1 <= 1'b0;
      flt_s  <= 1'b0;
    end else begin
      en_q1  <= bus.i_enable;
      en_s   <= en_q1;
      flt_q1 <= bus.i_fault;
      flt_s  <= flt_q1;
    end
  end

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    cool_d  = '0;
    case (state_q)
      IDLE: begin
        duty_d = '0;
        if (en_s) state_d = RAMP_UP;
      end
      RAMP_UP, RUN: begin
        if (!en_s) begin
          state_d = RAMP_DOWN;
        end else begin
          if (step) begin
            if (duty_q < target)      duty_d = duty_q + 1'b1;
            else if (duty_q > target) duty_d = duty_q - 1'b1;
          end
          // RUN is entered on the very edge the duty lands on target
          if (duty_d == target) state_d = RUN;
        end
      end
      RAMP_DOWN: begin
        if (en_s) begin
          state_d = RAMP_UP;
        end else begin
          if (step && duty_q != '0) duty_d = duty_q - 1'b1;
          if (duty_d == '0) state_d = IDLE;
        end
      end
      FAULT: begin
        duty_d = '0;
        // exit needs COOLDOWN consecutive cycles with both switch and fault low
        if (!en_s && !flt_s) begin
          if (cool_q == CD_W'(COOLDOWN - 1)) state_d = IDLE;
          else                               cool_d  = cool_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        duty_d  = '0;
      end
    endcase
    if (flt_s) begin
      state_d = FAULT;
      duty_d  = '0;
      cool_d  = '0;
    end
  end

  assign tick_d = (state_d != state_q || step) ? '0 : tick_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      duty_q   <= '0;
      tick_q   <= '0;
      cool_q   <= '0;
      pwm_en_q <= 1'b0;
      done_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      duty_q   <= duty_d;
      tick_q   <= tick_d;
      cool_q   <= cool_d;
      pwm_en_q <= (state_d == RAMP_UP) || (state_d == RUN) || (state_d == RAMP_DOWN);
      done_q   <= (state_d == RUN) && (duty_d == target);
      fault_q  <= (state_d == FAULT);
    end
  end

  assign bus.o_duty          = duty_q;
  assign bus.o_pwm_en        = pwm_en_q;
  assign bus.o_done          = done_q;
  assign bus.o_fault_latched = fault_q;
  assign bus.o_state         = state_q;
endmodule

// File: tb/tb_soft_start_sequencer.sv
// tb/tb_soft_start_sequencer.sv - directed/randomized checks of soft_start_sequencer against arithmetic expectations
module tb_soft_start_sequencer;
  localparam int DUTY_W = 8;
  localparam int RT     = 4;
  localparam int CD     = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  soft_start_sequencer_if #(.DUTY_W(DUTY_W)) bus ();

  soft_start_sequencer #(
    .DUTY_W(DUTY_W), .RAMP_TICK(RT), .COOLDOWN(CD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int tgt = 0;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_target(input int t);
    tgt = t;
    bus.i_target_duty = DUTY_W'(t);
  endtask

  // Flag outputs follow from the expected state and duty alone
  task automatic expect_all(input string tag, input int e_duty, input int e_state);
    chk({tag, ".state"}, int'(bus.o_state), e_state);
    chk({tag, ".duty"}, int'(bus.o_duty), e_duty);
    chk({tag, ".pwm_en"}, int'(bus.o_pwm_en), int'(e_state >= 1 && e_state <= 3));
    chk({tag, ".done"}, int'(bus.o_done), int'(e_state == 2 && e_duty == tgt));
    chk({tag, ".fault"}, int'(bus.o_fault_latched), int'(e_state == 4));
  endtask

  task automatic enter_ramp_up(input int from, input int prev);
    bus.i_enable = 1'b1;
    cyc();
    chk("up_lat1.state", int'(bus.o_state), prev);
    cyc();
    chk("up_lat2.state", int'(bus.o_state), prev);
    cyc();
    expect_all("up_entry", from, 1);
  endtask

  task automatic enter_ramp_down(input int d, input int prev);
    bus.i_enable = 1'b0;
    cyc();
    chk("dn_lat1.state", int'(bus.o_state), prev);
    cyc();
    chk("dn_lat2.state", int'(bus.o_state), prev);
    cyc();
    expect_all("down_entry", d, 3);
  endtask

  task automatic climb(input int from, input int to);
    for (int k = 1; k <= (to - from) * RT; k++) begin
      int d;
      cyc();
      d = from + k / RT;
      expect_all("climb", d, (d == to) ? 2 : 1);
    end
  endtask

  task automatic descend(input int from, input int to);
    for (int k = 1; k <= (from - to) * RT; k++) begin
      int d;
      cyc();
      d = from - k / RT;
      expect_all("descend", d, (d == 0) ? 0 : 3);
    end
  endtask

  initial begin
    int t1, t2, dmid, t3, m, p, run, post;
    bit exited;
    bit dirty_hist [0:63];

    bus.i_enable = 1'b0;
    bus.i_fault  = 1'b0;
    set_target(0);
    t1   = $urandom_range(9, 4);
    t2   = $urandom_range(t1 - 1, 2);
    dmid = $urandom_range(t2 - 1, 1);
    t3   = $urandom_range(9, 4);
    m    = $urandom_range((t3 - 1) * RT - 2, RT);
    p    = $urandom_range(9, 3);

    repeat (3) cyc();
    expect_all("reset", 0, 0);
    rst_n = 1'b1;
    cyc();
    expect_all("idle", 0, 0);

    // Ramp 0 -> t1
    set_target(t1);
    enter_ramp_up(0, 0);
    climb(0, t1);

    // Slew-limited tracking down to t2 while staying in RUN
    set_target(t2);
    for (int k = 1; k <= (t1 - t2) * RT; k++) begin
      int d;
      cyc();
      d = t1 - k / RT;
      expect_all("track", d, 2);
    end

    // Partial ramp-down, then resume upward from the current duty
    enter_ramp_down(t2, 2);
    descend(t2, dmid);
    enter_ramp_up(dmid, 3);
    climb(dmid, t2);

    // Full ramp-down to IDLE
    enter_ramp_down(t2, 2);
    descend(t2, 0);
    cyc();
    expect_all("idle_after_down", 0, 0);

    // Fault pulse mid-ramp: shutdown on the 3rd edge, latched while enable held
    set_target(t3);
    enter_ramp_up(0, 0);
    for (int k = 1; k <= m; k++) begin
      cyc();
      expect_all("fault_ramp", k / RT, 1);
    end
    bus.i_fault = 1'b1;
    cyc();
    expect_all("fault_lat1", (m + 1) / RT, 1);
    bus.i_fault = 1'b0;
    cyc();
    expect_all("fault_lat2", (m + 2) / RT, 1);
    cyc();
    expect_all("fault_entry", 0, 4);
    for (int k = 0; k < 25; k++) begin
      cyc();
      expect_all("fault_hold", 0, 4);
    end

    // Cooldown: exit after CD consecutive clean synchronized cycles; a fault
    // blip restarts the count. Raw inputs reach the decision two edges late.
    for (int i = 0; i < 64; i++) dirty_hist[i] = 1'b0;
    dirty_hist[0] = 1'b1;
    dirty_hist[1] = 1'b1;
    dirty_hist[2] = 1'b1;
    run = 0;
    exited = 1'b0;
    post = 0;
    for (int e = 1; e <= 40 && post < 3; e++) begin
      bus.i_enable = 1'b0;
      bus.i_fault  = (e == p);
      cyc();
      dirty_hist[e + 2] = (e == p);
      if (!exited) begin
        if (dirty_hist[e]) run = 0;
        else               run++;
        if (run == CD) exited = 1'b1;
      end
      if (exited) post++;
      expect_all("cooldown", 0, exited ? 0 : 4);
    end
    bus.i_fault = 1'b0;

    // Async reset from RUN
    set_target(5);
    enter_ramp_up(0, 0);
    climb(0, 5);
    #3 rst_n = 1'b0;
    #1;
    expect_all("async_reset", 0, 0);
    set_target(0);
    #2 rst_n = 1'b1;

    // Target 0 with enable still high: RAMP_UP then RUN at duty 0
    cyc();
    chk("t0_lat1.state", int'(bus.o_state), 0);
    cyc();
    chk("t0_lat2.state", int'(bus.o_state), 0);
    cyc();
    expect_all("t0_up", 0, 1);
    cyc();
    expect_all("t0_run", 0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
